// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle Moore controller for the 16-bit MIPS-style core.
// It decodes the current state into datapath strobes, waits for mem_ready in
// the memory states with an optional timeout, supports single-step debug, and
// counts retired instructions.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   opcode              IR[15:12], sampled in DECODE
//   zero                ALU zero flag (qualifies conditional PC write)
//   mem_ready           memory completes the current access this cycle
//   step_en, step       single-step enable, step request (level)
//   reg_dst .. pc_source datapath control strobes
//   pc_en               pc_write | (pc_write_cond & zero)
//   state               current state encoding
//   halted, error       status flags (held until reset)
//   retire              one-cycle pulse per completed instruction
//   instr_count         retired-instruction count (wraps)
//
// state     | meaning
// ----------+---------------------------------------------------
// FETCH     | read instruction, PC <= PC + 1 when memory ready
// DECODE    | branch target precompute, dispatch on opcode
// MEM_ADDR  | effective address = A + immediate
// MEM_READ  | data read, waits for mem_ready
// MEM_WB    | load result to register file (retires)
// MEM_WRITE | data write, waits for mem_ready (retires on ready)
// EXEC      | R-type ALU operation
// R_WB      | ALU result to register file (retires)
// BRANCH    | compare, conditional PC write (retires)
// JUMP      | PC <= jump target (retires)
// HALT      | stopped by halt opcode until reset
// ERROR     | illegal opcode or memory timeout, until reset
// STEP_WAIT | single-step pause before the next fetch
module mc_control_unit #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             step_en,
  input  logic             step,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             pc_en,
  output logic [3:0]       state,
  output logic             halted,
  output logic             error,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC      = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    HALT      = 4'd10,
    ERROR     = 4'd11,
    STEP_WAIT = 4'd12
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  state_t          state_q, state_d;
  logic [3:0]      opcode_q;
  logic [TO_W-1:0] wait_cnt;
  logic            step_q;
  logic            step_rise;
  logic            in_wait;
  logic            timed_out;

  assign state     = state_q;
  assign step_rise = step & ~step_q;
  assign in_wait   = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
  // mem_ready in the terminal-count cycle still lets the access complete.
  assign timed_out = TO_EN && (wait_cnt == TO_LAST) && !mem_ready;
  assign pc_en     = pc_write | (pc_write_cond & zero);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH;
      opcode_q    <= '0;
      wait_cnt    <= '0;
      step_q      <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step;
      if (state_q == DECODE) opcode_q <= opcode;
      if (retire) instr_count <= instr_count + 1'b1;
      // Any exit from a wait state happens with mem_ready high or via
      // ERROR, so clearing on "not stalling" also clears on entry.
      if (in_wait && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      else                       wait_cnt <= '0;
    end
  end

  always_comb begin
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    halted        = 1'b0;
    error         = 1'b0;
    retire        = 1'b0;
    state_d       = state_q;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)      state_d = DECODE;
        else if (timed_out) state_d = ERROR;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        casez (opcode)
          4'b0???:        state_d = EXEC;
          4'b1000,
          4'b1001:        state_d = MEM_ADDR;
          4'b1010:        state_d = BRANCH;
          4'b1011:        state_d = JUMP;
          4'b1111:        state_d = HALT;
          default:        state_d = ERROR;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode_q == 4'b1000) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)      state_d = MEM_WB;
        else if (timed_out) state_d = ERROR;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
        if (!mem_ready && timed_out) state_d = ERROR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      HALT:  halted = 1'b1;
      ERROR: error  = 1'b1;
      STEP_WAIT: begin
        if (!step_en || step_rise) state_d = FETCH;
      end
      default: state_d = ERROR;
    endcase
    if (retire) state_d = step_en ? STEP_WAIT : FETCH;
  end

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [3:0]       opcode;
  logic             zero, mem_ready, step_en, step;
  logic             reg_dst, reg_write, alu_src_a, mem_read, mem_write, mem_to_reg;
  logic             i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic             pc_en, halted, error, retire;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  always #5 clock = ~clock;

  mc_control_unit #(.CNT_W(CNT_W), .TIMEOUT(4), .TO_W(5)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .step_en(step_en), .step(step),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .pc_en(pc_en), .state(state), .halted(halted),
    .error(error), .retire(retire), .instr_count(instr_count)
  );

  typedef struct {
    logic       rst;
    logic [3:0] op;
    logic       z;
    logic       rdy;
    logic       sen;
    logic       stp;
    int         st;
    int         cnt;
  } vec_t;

  typedef struct {
    string       name;
    int          st;
    logic [19:0] ctl;
    int          cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic rst, logic [3:0] op, logic z, logic rdy,
                              logic sen, logic stp, int st, int cnt);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.rdy = rdy;
    v.sen = sen; v.stp = stp; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  // Strobe word written straight from the per-state strobe list.
  function automatic logic [19:0] exp_ctl(int st, logic rdy, logic z);
    logic rd, rw, asa, mr, mw, m2r, iod, irw, pw, pwc, ret;
    logic [1:0] asb, aop, psrc;
    {rd, rw, asa, mr, mw, m2r, iod, irw, pw, pwc, ret} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  begin asb = 2'b11; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; ret = 1; end
      5:  begin mw = 1; iod = 1; ret = rdy; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; ret = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; ret = 1; end
      9:  begin pw = 1; psrc = 2'b10; ret = 1; end
      default: ;
    endcase
    return {rd, rw, asa, mr, mw, m2r, iod, irw, pw, pwc, asb, aop, psrc,
            pw | (pwc & z), (st == 10), (st == 11), ret};
  endfunction

  function automatic logic [19:0] act_ctl();
    return {reg_dst, reg_write, alu_src_a, mem_read, mem_write, mem_to_reg,
            i_or_d, ir_write, pc_write, pc_write_cond, alu_src_b, alu_op,
            pc_source, pc_en, halted, error, retire};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clock);
    reset = v.rst; opcode = v.op; zero = v.z; mem_ready = v.rdy;
    step_en = v.sen; step = v.stp;
    e.name = tag; e.st = v.st; e.ctl = exp_ctl(v.st, v.rdy, v.z); e.cnt = v.cnt;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check({e.name, " state"}, int'(state), e.st);
    check({e.name, " strobes"}, int'(act_ctl()), int'(e.ctl));
    check({e.name, " count"}, int'(instr_count), e.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int found;
    // R-type: 0,1,6,7,0
    tbl.push_back(mk(0, 4'd1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd1, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 4'd1, 0, 1, 0, 0, 6, 0));
    tbl.push_back(mk(0, 4'd1, 0, 1, 0, 0, 7, 0));
    tbl.push_back(mk(1, 4'd1, 0, 1, 0, 0, 0, 1));
    // Load with three stall cycles, ready lands on the timeout boundary
    tbl.push_back(mk(0, 4'd8, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd8, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 4'd8, 0, 1, 0, 0, 2, 0));
    tbl.push_back(mk(0, 4'd8, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 4'd8, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 4'd8, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 4'd8, 0, 1, 0, 0, 3, 0));
    tbl.push_back(mk(0, 4'd8, 0, 1, 0, 0, 4, 0));
    tbl.push_back(mk(1, 4'd8, 0, 1, 0, 0, 0, 1));
    // BEQ taken then not taken
    tbl.push_back(mk(0, 4'd10, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd10, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 4'd10, 1, 1, 0, 0, 8, 0));
    tbl.push_back(mk(0, 4'd10, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd10, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 4'd10, 0, 1, 0, 0, 8, 1));
    tbl.push_back(mk(1, 4'd10, 0, 1, 0, 0, 0, 2));
    // Dead memory in FETCH: ERROR on the 5th cycle, sticky until reset
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 11, 0));
    tbl.push_back(mk(0, 4'd0, 0, 1, 0, 0, 11, 0));
    tbl.push_back(mk(1, 4'd0, 0, 1, 0, 0, 11, 0));
    // Illegal opcode 1110
    tbl.push_back(mk(0, 4'd14, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd14, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 4'd14, 0, 1, 0, 0, 11, 0));
    tbl.push_back(mk(1, 4'd14, 0, 1, 0, 0, 11, 0));
    // Halt ignores step/step_en
    tbl.push_back(mk(0, 4'd15, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd15, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 4'd15, 0, 1, 0, 1, 10, 0));
    tbl.push_back(mk(0, 4'd15, 0, 1, 1, 0, 10, 0));
    tbl.push_back(mk(1, 4'd15, 0, 1, 0, 0, 10, 0));
    // Store: reset mid-write, then a store completing on ready
    tbl.push_back(mk(0, 4'd9, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd9, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 4'd9, 0, 1, 0, 0, 2, 0));
    tbl.push_back(mk(0, 4'd9, 0, 0, 0, 0, 5, 0));
    tbl.push_back(mk(1, 4'd9, 0, 0, 0, 0, 5, 0));
    tbl.push_back(mk(0, 4'd9, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd9, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'd9, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 4'd9, 0, 1, 0, 0, 2, 0));
    tbl.push_back(mk(0, 4'd9, 0, 1, 0, 0, 5, 0));
    tbl.push_back(mk(1, 4'd9, 0, 1, 0, 0, 0, 1));

    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    step_en = 1'b0; step = 1'b0;
    repeat (2) @(posedge clock);

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // Single step: two jumps, one per rising edge of step
    apply(mk(0, 4'd11, 0, 1, 1, 0, 0, 0), "step_f1");
    apply(mk(0, 4'd11, 0, 1, 1, 0, 1, 0), "step_d1");
    apply(mk(0, 4'd11, 0, 1, 1, 0, 9, 0), "step_j1");
    apply(mk(0, 4'd11, 0, 1, 1, 0, 12, 1), "step_w1a");
    apply(mk(0, 4'd11, 0, 1, 1, 0, 12, 1), "step_w1b");
    apply(mk(0, 4'd11, 0, 1, 1, 0, 12, 1), "step_w1c");
    found = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      step = 1'b1;
      #1;
      if (state == 4'd0) begin
        found = 1;
        break;
      end
    end
    check("step_release", found, 1);
    check("step_release count", int'(instr_count), 1);
    apply(mk(0, 4'd11, 0, 1, 1, 1, 1, 1), "step_d2");
    apply(mk(0, 4'd11, 0, 1, 1, 1, 9, 1), "step_j2");
    apply(mk(0, 4'd11, 0, 1, 1, 1, 12, 2), "step_w2");
    apply(mk(0, 4'd11, 0, 1, 0, 1, 12, 2), "step_en_drop");
    apply(mk(0, 4'd11, 0, 1, 0, 1, 0, 2), "step_en_fetch");

    // Counter wraps from all-ones to zero
    apply(mk(1, 4'd11, 0, 1, 0, 0, 1, 2), "wrap_rst");
    for (int i = 0; i < 16; i++) begin
      apply(mk(0, 4'd11, 0, 1, 0, 0, 0, i), $sformatf("wrap_f%0d", i));
      apply(mk(0, 4'd11, 0, 1, 0, 0, 1, i), $sformatf("wrap_d%0d", i));
      apply(mk(0, 4'd11, 0, 1, 0, 0, 9, i), $sformatf("wrap_j%0d", i));
    end
    apply(mk(0, 4'd11, 0, 1, 0, 0, 0, 0), "wrap_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
